// File: rtl/interval_timer_sequencer_pkg.sv
// Shared definitions for the interval timer sequencer: timer register map,
// control-register bit positions, client opcode and sequencer state encodings.
// Optional macro TIMER_SEQ_AUTO_ACK_EN adds the interrupt-acknowledge states.
package timer_seq_pkg;

  // Interval timer s1 register addresses
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [1:0] {
    OP_PROGRAM  = 2'd0,
    OP_STOP     = 2'd1,
    OP_SNAPSHOT = 2'd2,
    OP_CLEAR_TO = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_STOP,
    S_WR_PL,
    S_WR_PH,
    S_WR_ST,
    S_WR_START,
    S_SNAP_WR,
    S_SNAP_RL,
    S_SNAP_RH,
    S_SNAP_CAP,
    S_DONE
`ifdef TIMER_SEQ_AUTO_ACK_EN
    , S_ACK
    , S_ACK_WAIT
`endif
  } state_e;

  // Control word that starts the timer with the requested mode bits.
  function automatic logic [15:0] start_word(input logic cont, input logic irq_en);
    logic [15:0] w;
    w             = '0;
    w[CTRL_STOP]  = 1'b0;
    w[CTRL_START] = 1'b1;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = irq_en;
    return w;
  endfunction

endpackage

// File: rtl/interval_timer_sequencer_if.sv
// Bundle of client command/response and timer s1 bus signals.
// master: the sequencer (drives cmd_ready, rsp_*, tmr_* requests).
// slave: the surroundings (client drives cmd_*, timer drives tmr_readdata/tmr_irq).
interface interval_timer_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        cmd_continuous;
  logic        cmd_irq_en;
  logic        rsp_valid;
  logic [31:0] rsp_snapshot;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  modport master (
    input  cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
    input  tmr_readdata, tmr_irq,
    output cmd_ready, rsp_valid, rsp_snapshot,
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
    output tmr_readdata, tmr_irq,
    input  cmd_ready, rsp_valid, rsp_snapshot,
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
  );
endinterface

// File: rtl/interval_timer_sequencer.sv
// Purpose: turns single-beat client commands into interval-timer s1 access sequences.
// Latency: accept->rsp_valid = 6 (program), 2 (stop), 2 (clear timeout), 5 (snapshot).
// Backpressure: cmd_ready only in IDLE; one command in flight, no pipelining.
// Ports: clk, reset_n (async active-low), bus (master modport: cmd/rsp + tmr s1),
// irq_count (only with TIMER_SEQ_AUTO_ACK_EN, which auto-clears timer timeouts).
module interval_timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter logic [15:0] CTRL_STOP_WORD = 16'h0008
`ifdef TIMER_SEQ_AUTO_ACK_EN
  , parameter int IRQ_CNT_W = 16
`endif
) (
  input  logic clk,
  input  logic reset_n,
`ifdef TIMER_SEQ_AUTO_ACK_EN
  output logic [IRQ_CNT_W-1:0] irq_count,
`endif
  interval_timer_sequencer_if.master bus
);

  state_e      state, next_state;
  logic        ready_q;
  logic        accept;
  cmd_op_e     op_q;
  logic [31:0] period_q;
  logic        cont_q, irq_en_q;
  logic [15:0] snap_lo;

  // Timer request for the coming cycle; registered so tmr_* are glitch-free.
  logic [2:0]  nxt_addr;
  logic        nxt_cs, nxt_wr_n;
  logic [15:0] nxt_wdata;

`ifdef TIMER_SEQ_AUTO_ACK_EN
  // A pending irq wins over a waiting command, so hide ready while it is high.
  assign bus.cmd_ready = ready_q & ~bus.tmr_irq;
`else
  assign bus.cmd_ready = ready_q;
`endif

  assign accept = bus.cmd_valid & bus.cmd_ready;

  always_comb begin
    next_state = state;
    nxt_addr   = ADDR_STATUS;
    nxt_cs     = 1'b0;
    nxt_wr_n   = 1'b1;
    nxt_wdata  = '0;

    case (state)
      S_IDLE: begin
`ifdef TIMER_SEQ_AUTO_ACK_EN
        if (bus.tmr_irq) next_state = S_ACK;
        else
`endif
        if (accept) begin
          case (cmd_op_e'(bus.cmd_op))
            OP_PROGRAM:  next_state = S_WR_STOP;
            OP_STOP:     next_state = S_WR_STOP;
            OP_SNAPSHOT: next_state = S_SNAP_WR;
            OP_CLEAR_TO: next_state = S_WR_ST;
            default:     next_state = S_IDLE;
          endcase
        end
      end
      S_WR_STOP:  next_state = (op_q == OP_PROGRAM) ? S_WR_PL : S_DONE;
      S_WR_PL:    next_state = S_WR_PH;
      // The timer force-reloads its counter the cycle after the period_h
      // write; status clear fills that slot so start lands after the reload.
      S_WR_PH:    next_state = S_WR_ST;
      S_WR_ST:    next_state = (op_q == OP_PROGRAM) ? S_WR_START : S_DONE;
      S_WR_START: next_state = S_DONE;
      S_SNAP_WR:  next_state = S_SNAP_RL;
      S_SNAP_RL:  next_state = S_SNAP_RH;
      S_SNAP_RH:  next_state = S_SNAP_CAP;
      S_SNAP_CAP: next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
`ifdef TIMER_SEQ_AUTO_ACK_EN
      S_ACK:      next_state = S_ACK_WAIT;
      // One idle cycle lets the cleared irq reach us before IDLE samples it.
      S_ACK_WAIT: next_state = S_IDLE;
`endif
      default:    next_state = S_IDLE;
    endcase

    case (next_state)
      S_WR_STOP:  begin nxt_cs = 1'b1; nxt_wr_n = 1'b0; nxt_addr = ADDR_CONTROL; nxt_wdata = CTRL_STOP_WORD; end
      S_WR_PL:    begin nxt_cs = 1'b1; nxt_wr_n = 1'b0; nxt_addr = ADDR_PERIODL; nxt_wdata = period_q[15:0]; end
      S_WR_PH:    begin nxt_cs = 1'b1; nxt_wr_n = 1'b0; nxt_addr = ADDR_PERIODH; nxt_wdata = period_q[31:16]; end
      S_WR_ST:    begin nxt_cs = 1'b1; nxt_wr_n = 1'b0; nxt_addr = ADDR_STATUS; end
      S_WR_START: begin nxt_cs = 1'b1; nxt_wr_n = 1'b0; nxt_addr = ADDR_CONTROL; nxt_wdata = start_word(cont_q, irq_en_q); end
      S_SNAP_WR:  begin nxt_cs = 1'b1; nxt_wr_n = 1'b0; nxt_addr = ADDR_SNAPL; end
      S_SNAP_RL:  begin nxt_cs = 1'b1; nxt_addr = ADDR_SNAPL; end
      S_SNAP_RH:  begin nxt_cs = 1'b1; nxt_addr = ADDR_SNAPH; end
`ifdef TIMER_SEQ_AUTO_ACK_EN
      S_ACK:      begin nxt_cs = 1'b1; nxt_wr_n = 1'b0; nxt_addr = ADDR_STATUS; end
`endif
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      ready_q            <= 1'b0;
      op_q               <= OP_PROGRAM;
      period_q           <= '0;
      cont_q             <= 1'b0;
      irq_en_q           <= 1'b0;
      snap_lo            <= '0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_snapshot   <= '0;
      bus.tmr_address    <= '0;
      bus.tmr_chipselect <= 1'b0;
      bus.tmr_write_n    <= 1'b1;
      bus.tmr_writedata  <= '0;
`ifdef TIMER_SEQ_AUTO_ACK_EN
      irq_count          <= '0;
`endif
    end else begin
      state              <= next_state;
      ready_q            <= (next_state == S_IDLE);
      bus.rsp_valid      <= (next_state == S_DONE);
      bus.tmr_address    <= nxt_addr;
      bus.tmr_chipselect <= nxt_cs;
      bus.tmr_write_n    <= nxt_wr_n;
      bus.tmr_writedata  <= nxt_wdata;
      if (accept) begin
        op_q     <= cmd_op_e'(bus.cmd_op);
        period_q <= bus.cmd_period;
        cont_q   <= bus.cmd_continuous;
        irq_en_q <= bus.cmd_irq_en;
      end
      // readdata trails the read address by one cycle.
      if (state == S_SNAP_RH)  snap_lo <= bus.tmr_readdata;
      if (state == S_SNAP_CAP) bus.rsp_snapshot <= {bus.tmr_readdata, snap_lo};
`ifdef TIMER_SEQ_AUTO_ACK_EN
      if (state == S_ACK) irq_count <= irq_count + IRQ_CNT_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_interval_timer_sequencer.sv
module tb_interval_timer_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_snap = '0;

  interval_timer_sequencer_if bus();

`ifdef TIMER_SEQ_AUTO_ACK_EN
  logic [1:0] irq_count;
  interval_timer_sequencer #(.CTRL_STOP_WORD(16'h0008), .IRQ_CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .irq_count(irq_count), .bus(bus));
`else
  interval_timer_sequencer #(.CTRL_STOP_WORD(16'h0008)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Behavioural interval timer plus bus/handshake logging.
  typedef struct packed {logic [31:0] cyc; logic wr; logic [2:0] a; logic [15:0] d;} acc_t;
  typedef struct packed {logic wr; logic [2:0] a; logic [15:0] d;} xacc_t;
  acc_t        acc_log[$];
  int unsigned acc_cyc_q[$];
  int unsigned rsp_cyc_q[$];
  int unsigned cyc = 0;
  int unsigned to_events = 0;
  logic [15:0] m_ctrl = '0;
  logic        m_to = 1'b0;
  logic        m_run = 1'b0;
  logic [31:0] m_period = '0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_snap = '0;
  logic [15:0] m_rdata = '0;
  logic        preset_en = 1'b0;
  logic [31:0] preset_val = '0;

  assign bus.tmr_readdata = m_rdata;
  assign bus.tmr_irq      = m_to & m_ctrl[0];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tmr_chipselect)
      acc_log.push_back({cyc, ~bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata});
    if (bus.cmd_valid && bus.cmd_ready) acc_cyc_q.push_back(cyc);
    if (bus.rsp_valid) rsp_cyc_q.push_back(cyc);
    if (m_run) begin
      if (m_cnt == 0) begin
        m_to <= 1'b1;
        to_events <= to_events + 1;
        m_cnt <= m_period;
        if (!m_ctrl[1]) m_run <= 1'b0;
      end else m_cnt <= m_cnt - 1;
    end
    if (bus.tmr_chipselect && !bus.tmr_write_n) begin
      case (bus.tmr_address)
        3'd0: m_to <= 1'b0;
        3'd1: begin
          m_ctrl <= bus.tmr_writedata;
          if (bus.tmr_writedata[2]) m_run <= 1'b1;
          if (bus.tmr_writedata[3]) m_run <= 1'b0;
        end
        3'd2: begin m_period[15:0]  <= bus.tmr_writedata; m_cnt <= {m_period[31:16], bus.tmr_writedata}; end
        3'd3: begin m_period[31:16] <= bus.tmr_writedata; m_cnt <= {bus.tmr_writedata, m_period[15:0]}; end
        3'd4, 3'd5: m_snap <= m_cnt;
        default: ;
      endcase
    end
    if (bus.tmr_chipselect && bus.tmr_write_n) begin
      case (bus.tmr_address)
        3'd0: m_rdata <= {14'h0, m_run, m_to};
        3'd1: m_rdata <= m_ctrl;
        3'd2: m_rdata <= m_period[15:0];
        3'd3: m_rdata <= m_period[31:16];
        3'd4: m_rdata <= m_snap[15:0];
        3'd5: m_rdata <= m_snap[31:16];
        default: m_rdata <= '0;
      endcase
    end
    if (preset_en) begin
      m_cnt <= preset_val;
      m_run <= 1'b0;
    end
  end

  task automatic preset(input logic [31:0] v);
    @(negedge clk);
    preset_val = v;
    preset_en  = 1'b1;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  // Issue one command and check accesses, latency, response and handshake.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] per, input logic cont,
                         input logic ien, input string tag);
    xacc_t exp_q[$];
    int    n;
    int    lat;
    case (op)
      2'd0: begin
        exp_q.push_back({1'b1, 3'd1, 16'h0008});
        exp_q.push_back({1'b1, 3'd2, per[15:0]});
        exp_q.push_back({1'b1, 3'd3, per[31:16]});
        exp_q.push_back({1'b1, 3'd0, 16'h0000});
        exp_q.push_back({1'b1, 3'd1, {12'h000, 1'b0, 1'b1, cont, ien}});
        lat = 6;
      end
      2'd1: begin exp_q.push_back({1'b1, 3'd1, 16'h0008}); lat = 2; end
      2'd2: begin
        exp_q.push_back({1'b1, 3'd4, 16'h0000});
        exp_q.push_back({1'b0, 3'd4, 16'h0000});
        exp_q.push_back({1'b0, 3'd5, 16'h0000});
        lat = 5;
      end
      default: begin exp_q.push_back({1'b1, 3'd0, 16'h0000}); lat = 2; end
    endcase

    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s ready_wait: cmd_ready=%b want 1", tag, bus.cmd_ready); return;
    end
    acc_log.delete(); acc_cyc_q.delete(); rsp_cyc_q.delete();
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_period = per;
    bus.cmd_continuous = cont; bus.cmd_irq_en = ien;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_period = $urandom(); bus.cmd_op = 2'($urandom_range(0, 3));
    bus.cmd_continuous = ~cont; bus.cmd_irq_en = ~ien;
    n = 0;
    while (rsp_cyc_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (rsp_cyc_q.size() == 0 || acc_cyc_q.size() != 1) begin
      fails++; $display("FAIL %s rsp_wait: rsp=%0d accepts=%0d want 1/1", tag, rsp_cyc_q.size(), acc_cyc_q.size());
      return;
    end
    tests++;
    if (rsp_cyc_q[0] - acc_cyc_q[0] != lat) begin
      fails++; $display("FAIL %s latency: got %0d want %0d", tag, rsp_cyc_q[0] - acc_cyc_q[0], lat);
    end
    tests++;
    if (acc_log.size() != exp_q.size()) begin
      fails++; $display("FAIL %s access_count: got %0d want %0d", tag, acc_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
      tests++;
      if (acc_log[i].wr !== exp_q[i].wr || acc_log[i].a !== exp_q[i].a ||
          (exp_q[i].wr && acc_log[i].d !== exp_q[i].d) || acc_log[i].cyc != acc_cyc_q[0] + 1 + i) begin
        fails++;
        $display("FAIL %s access%0d: got wr=%b a=%0d d=%h cyc=+%0d want wr=%b a=%0d d=%h cyc=+%0d", tag, i,
                 acc_log[i].wr, acc_log[i].a, acc_log[i].d, acc_log[i].cyc - acc_cyc_q[0],
                 exp_q[i].wr, exp_q[i].a, exp_q[i].d, 1 + i);
      end
    end
    tests++;
    if (bus.rsp_snapshot !== exp_snap) begin
      fails++; $display("FAIL %s snapshot: got %h want %h", tag, bus.rsp_snapshot, exp_snap);
    end
    tests++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL %s after_rsp: ready=%b rsp_valid=%b want 1/0", tag, bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_period = '0;
    bus.cmd_continuous = 1'b0; bus.cmd_irq_en = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_snapshot !== 32'h0 ||
        bus.tmr_chipselect !== 1'b0 || bus.tmr_write_n !== 1'b1 || bus.tmr_address !== 3'd0 ||
        bus.tmr_writedata !== 16'h0) begin
      fails++;
      $display("FAIL reset_values: ready=%b rsp=%b snap=%h cs=%b wr_n=%b addr=%0d wd=%h want 0/0/0/0/1/0/0",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_snapshot, bus.tmr_chipselect,
               bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_program;
    run_cmd(2'd0, 32'h00BE_BC1F, 1'b1, 1'b1, "program");
    tests++;
    if (m_run !== 1'b1 || m_period !== 32'h00BE_BC1F) begin
      fails++; $display("FAIL program_timer: running=%b period=%h want 1/00bebc1f", m_run, m_period);
    end
  endtask

  task automatic test_snapshot;
    preset(32'h1234_5678);
    exp_snap = 32'h1234_5678;
    run_cmd(2'd2, 32'h0, 1'b0, 1'b0, "snapshot");
  endtask

  task automatic test_back_to_back;
    logic [31:0] a_per, b_per;
    int n;
    a_per = 32'h0003_1111; b_per = 32'h0005_2222;
    acc_log.delete(); acc_cyc_q.delete(); rsp_cyc_q.delete();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_period = a_per;
    bus.cmd_continuous = 1'b0; bus.cmd_irq_en = 1'b0;
    @(negedge clk);
    n = 0;
    while (rsp_cyc_q.size() == 0 && n < 50) begin bus.cmd_period = $urandom(); @(negedge clk); n++; end
    bus.cmd_period = b_per;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (rsp_cyc_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (rsp_cyc_q.size() != 2 || acc_cyc_q.size() != 2 || acc_log.size() != 10) begin
      fails++; $display("FAIL b2b_counts: rsp=%0d acc=%0d writes=%0d want 2/2/10",
                        rsp_cyc_q.size(), acc_cyc_q.size(), acc_log.size());
      return;
    end
    tests++;
    if (acc_cyc_q[1] != rsp_cyc_q[0] + 1) begin
      fails++; $display("FAIL b2b_accept: got +%0d after rsp want +1", acc_cyc_q[1] - rsp_cyc_q[0]);
    end
    tests++;
    if ({acc_log[2].d, acc_log[1].d} !== a_per || {acc_log[7].d, acc_log[6].d} !== b_per) begin
      fails++; $display("FAIL b2b_period: got %h/%h want %h/%h", {acc_log[2].d, acc_log[1].d},
                        {acc_log[7].d, acc_log[6].d}, a_per, b_per);
    end
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] per;
    for (int i = 0; i < 16; i++) begin
      op  = 2'($urandom_range(0, 3));
      per = $urandom() | 32'h0001_0000;
      if (op == 2'd2) begin
        exp_snap = $urandom();
        preset(exp_snap);
      end
      run_cmd(op, per, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_period = 32'h0007_0001;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!(bus.tmr_chipselect === 1'b1 && bus.tmr_address === 3'd3) && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (bus.tmr_address !== 3'd3) begin
      fails++; $display("FAIL mid_reach_ph: addr=%0d want 3", bus.tmr_address);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (bus.tmr_chipselect !== 1'b0 || bus.tmr_write_n !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      fails++; $display("FAIL mid_reset_outputs: cs=%b wr_n=%b ready=%b want 0/1/0",
                        bus.tmr_chipselect, bus.tmr_write_n, bus.cmd_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_snap = '0;
    @(negedge clk);
    tests++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_snapshot !== 32'h0) begin
      fails++; $display("FAIL mid_release: ready=%b snap=%h want 1/0", bus.cmd_ready, bus.rsp_snapshot);
    end
  endtask

`ifdef TIMER_SEQ_AUTO_ACK_EN
  task automatic test_auto_ack;
    int unsigned base;
    int n, acks;
    int unsigned ack_cyc;
    run_cmd(2'd0, 32'd10, 1'b1, 1'b1, "ack_program");
    acc_log.delete();
    base = to_events;
    for (int k = 3; k <= 5; k += 2) begin
      n = 0;
      while (to_events - base < k && n < 200) begin @(negedge clk); n++; end
      repeat (4) @(negedge clk);
      acks = 0;
      foreach (acc_log[i]) if (acc_log[i].wr && acc_log[i].a == 3'd0) acks++;
      tests++;
      if (irq_count !== 2'(k) || acks != k) begin
        fails++; $display("FAIL ack_count%0d: irq_count=%0d writes=%0d want %0d/%0d", k, irq_count, acks, k % 4, k);
      end
    end
    n = 0;
    while (bus.tmr_irq !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    acc_cyc_q.delete(); rsp_cyc_q.delete(); acc_log.delete();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1;
    n = 0;
    while (acc_cyc_q.size() == 0 && n < 20) begin @(negedge clk); n++; end
    bus.cmd_valid = 1'b0;
    ack_cyc = (acc_log.size() > 0) ? acc_log[0].cyc : 0;
    tests++;
    if (acc_cyc_q.size() != 1 || acc_log.size() == 0 || acc_log[0].a != 3'd0 || acc_cyc_q[0] != ack_cyc + 2) begin
      fails++; $display("FAIL ack_delay: accepts=%0d accept=%0d ack=%0d want accept=ack+2",
                        acc_cyc_q.size(), (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : 0, ack_cyc);
    end
    repeat (6) @(negedge clk);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_program();
    test_snapshot();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef TIMER_SEQ_AUTO_ACK_EN
    test_auto_ack();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/interval_timer_sequencer.md
Name: interval_timer_sequencer

Overview:
- Avalon-MM write/read master that sits directly upstream of the interval timer's s1 slave.
- Turns single-beat commands from a control client into the timer's register access sequences: program and start, stop, snapshot read, and timeout clear.
- Returns 32-bit snapshot results to the client.
- Monitors the timer's irq output.

Parameters:
- IRQ_CNT_W, 16, width of irq_count (optional feature only).
- CTRL_STOP_WORD, 16'h0008, data written to control register to stop the timer.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=program+start, 1=stop, 2=snapshot, 3=clear timeout
- cmd_period  in  32  period value for op 0
- cmd_continuous  in  1  continuous bit for op 0
- cmd_irq_en  in  1  interrupt-enable bit for op 0
- rsp_valid  out  1  one-cycle pulse when a command completes
- rsp_snapshot  out  32  snapshot result; holds last value
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  timer chipselect
- tmr_write_n  out  1  timer write strobe, active-low
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data; registered in the timer, valid the cycle after the address
- tmr_irq  in  1  timer interrupt, level

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 the first cycle after; rsp_valid=0; rsp_snapshot=0; tmr_chipselect=0; tmr_write_n=1; tmr_address=0; tmr_writedata=0; state=IDLE.
- All tmr_* outputs are registered.
- One access per cycle. The timer has no waitrequest, so every write completes in its issue cycle.
- Outside access states: chipselect=0, write_n=1.
- Handshake:
  - Command accepted when cmd_valid && cmd_ready.
  - cmd_period and the control bits are latched at acceptance; later changes are ignored.
  - cmd_ready drops the cycle after acceptance and returns in the cycle after rsp_valid.
- Op 0 sequence (one state per cycle):
  - WR_STOP: addr 1, data CTRL_STOP_WORD.
  - WR_PL: addr 2, data period[15:0].
  - WR_PH: addr 3, data period[31:16].
  - WR_ST: addr 0, data 0, clears timeout.
  - WR_START: addr 1, data {12'b0, 1'b0, 1'b1, cont, irq_en}.
  - DONE, then IDLE.
  - Start is issued 2 cycles after the period_h write, after the timer's force_reload cycle.
- Op 1: WR_STOP, then DONE.
- Op 3: WR_ST, then DONE.
- Op 2 sequence:
  - SNAP_WR: addr 4, write, data 0.
  - SNAP_RL: addr 4, read (chipselect=1, write_n=1).
  - SNAP_RH: addr 5, read; capture tmr_readdata into low half this cycle.
  - SNAP_CAP: capture tmr_readdata into high half.
  - DONE: rsp_valid=1 and rsp_snapshot updated.
- Latency, acceptance to rsp_valid: op0 6 cycles, op1 2, op3 2, op2 5.
- rsp_snapshot changes only on op 2 DONE.
- No pipelining: one command in flight.
- Reset mid-sequence: outputs return to idle values immediately (async). A partially programmed timer is left as-is; the client re-issues.
- cmd_op values are fully decoded; there is no illegal op.

Optional Feature:
- Macro TIMER_SEQ_AUTO_ACK_EN.
- Defined:
  - In IDLE with tmr_irq=1, the block takes priority over cmd_valid and enters ACK, issuing addr 0, data 0 for one cycle (cmd_ready=0 that cycle).
  - irq_count output (IRQ_CNT_W bits, reset 0) increments once per ACK and wraps from all-ones to 0.
  - After ACK the block waits in ACK_WAIT for one cycle so the deasserted irq propagates, then returns to IDLE.
  - No rsp_valid for ACK.
- Undefined: no irq_count port; tmr_irq is unused; the ACK states are absent.

Decomposition:
- Package timer_seq_pkg holds:
  - timer register address constants: STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5;
  - control bit positions: ITO=0, CONT=1, START=2, STOP=3;
  - the cmd_op enum;
  - the state enum.
- Single module; no sub-module needed.

Test Plan:
- Op 0, period 32'h00BE_BC1F, cont=1, irq_en=1 -> writes (1,0008), (2,BC1F), (3,00BE), (0,0000), (1,0007) on consecutive cycles; rsp_valid 6 cycles after accept; connected timer shows running=1.
- Op 2 against a timer model whose counter reads 32'h1234_5678 at the snap write -> rsp_snapshot=32'h1234_5678, rsp_valid 5 cycles after accept, read addresses 4 then 5.
- cmd_valid held high with changing cmd_period during op 0 -> only the first value is written; the next command is accepted in the cycle after rsp_valid.
- reset_n asserted during WR_PH -> chipselect=0, write_n=1 in the same cycle; after release cmd_ready=1 and rsp_snapshot=0.
- TIMER_SEQ_AUTO_ACK_EN with timer period 10, continuous -> one addr-0 write per timeout; irq_count=3 after 3 timeouts; command arriving together with tmr_irq is delayed 2 cycles.
- TIMER_SEQ_AUTO_ACK_EN with IRQ_CNT_W=2 and 5 timeouts -> irq_count=1 (wrap).
